// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: a full adder built from two half adders and an OR,
// one carry flip-flop, and shift registers for operands and result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s1;
  logic             w_c1;
  logic             w_bit;
  logic             w_c2;
  logic             w_cnext;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Full adder on the current LSBs: HA1(SA0,SB0) then HA2(s1,carry)
  assign w_s1       = r_sa[0] ^ r_sb[0];
  assign w_c1       = r_sa[0] & r_sb[0];
  assign w_bit      = w_s1 ^ r_carry;
  assign w_c2       = w_s1 & r_carry;
  assign w_cnext    = w_c1 | w_c2;
  assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          r_res   <= w_res_next;
          r_carry <= w_cnext;
          r_cnt   <= r_cnt + CW'(1);
          // Last bit: publish the completed result including this edge's MSB
          if (w_last) begin
            r_sum   <= w_res_next;
            r_cout  <= w_cnext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed operands, expected {cout,sum} queued at issue.
module tb_serial_adder;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [WIDTH:0] exp_q[$];
  int n_checks;
  int n_errors;
  int n_done;
  int n_pushed;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] s, input logic c);
    exp_q.push_back({c, s});
    n_pushed++;
  endtask

  // Monitor: every done pulse pops one expected result
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        logic [WIDTH:0] e;
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sum", 32'(bus.sum), 32'(e[WIDTH-1:0]));
          check("cout", 32'(bus.cout), 32'(e[WIDTH]));
        end
      end
    end
  end

  task automatic wait_done(output int busy_cycles);
    bit ok;
    busy_cycles = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
    end
    if (!ok) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] es, input logic ec);
    int nb;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    push_exp(es, ec);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(nb);
    check("busy_cycles", 32'(nb), 32'(WIDTH));
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int d0;
    int t1;
    int t2;
    n_checks  = 0;
    n_errors  = 0;
    n_done    = 0;
    n_pushed  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_sum", 32'(bus.sum), 32'(0));
    check("rst_cout", 32'(bus.cout), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic add and carry ripple
    run_op(8'h5A, 8'h3C, 8'h96, 1'b0);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);

    // Start while busy is ignored
    d0 = n_done;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    push_exp(8'h03, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(nb);
    repeat (15) @(negedge clk);
    check("busy_ignore_dones", 32'(n_done - d0), 32'(1));
    check("busy_ignore_sum", 32'(bus.sum), 32'(8'h03));

    // Back-to-back with start held high
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    push_exp(8'h30, 1'b0);
    @(posedge clk); #1;
    bus.a     = 8'h80;
    bus.b     = 8'h80;
    push_exp(8'h00, 1'b1);
    wait_done(nb);
    t1 = cyc;
    check("b2b_busy_in_done", 32'(bus.busy), 32'(0));
    wait_done(nb);
    t2 = cyc;
    bus.start = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'(WIDTH + 1));
    check("b2b_busy_cycles", 32'(nb), 32'(WIDTH));
    repeat (3) @(negedge clk);

    // Reset asserted mid-operation, during bit 4
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_sum", 32'(bus.sum), 32'(0));
    check("abort_cout", 32'(bus.cout), 32'(0));
    #4;
    rst_n = 1'b1;
    d0 = n_done;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'(0));
    check("abort_idle_busy", 32'(bus.busy), 32'(0));
    run_op(8'h07, 8'h09, 8'h10, 1'b0);

    // Result holds while idle
    run_op(8'h22, 8'h11, 8'h33, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold_sum", 32'(bus.sum), 32'(8'h33));
      check("hold_done", 32'(bus.done), 32'(0));
    end

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("done_total", 32'(n_done), 32'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
